pipelined_bw_multiplier: RTL and testbench

- Parametrised, pipelined Baugh-Wooley array multiplier for the TPU ALU. Successor to the fixed 8x8 combinational signed multiplier.
- Operand width is a parameter. Signed or unsigned mode is selected per transaction.
- Partial-product generation and 4:2 compression are split across registered stages. Valid/ready handshakes with per-stage bubble collapsing on both sides.
- Sits between the operand fetch FIFO and the MAC accumulator in each PE.

---
 rtl/pipelined_bw_multiplier.sv | 118 +++++++++++
 tb/tb_pipelined_bw_multiplier.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_bw_multiplier.sv
// Three-stage pipelined Baugh-Wooley multiplier with per-stage valid/ready flow control.
// S1 holds partial products, S2 a carry-save pair, S3 the final product.
module pipelined_bw_multiplier #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_signed,
    output logic [TAG_W-1:0]   out_tag
);
    localparam int PW   = 2 * WIDTH;
    localparam int ROWS = WIDTH + 1;
    localparam logic [PW-1:0] CORR = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));

    logic v1, v2, v3;
    logic ready1, ready2, ready3;

    logic [PW-1:0]    pp1 [ROWS];
    logic             sgn1, sgn2, sgn3;
    logic [TAG_W-1:0] tag1, tag2, tag3;
    logic [PW-1:0]    sum2, carry2;
    logic [PW-1:0]    p3;

    logic [PW-1:0]    pp_next [ROWS];
    logic [WIDTH-1:0] row_bits;
    logic [PW-1:0]    cs_sum, cs_carry, cs_maj;

    // A stage can take new data when empty or when its own content moves on.
    assign ready3   = !v3 || out_ready;
    assign ready2   = !v2 || ready3;
    assign ready1   = !v1 || ready2;
    assign in_ready = ready1;

    // Signed rows invert terms that pair exactly one operand MSB; the correction row supplies the constant 1s.
    always_comb begin
        row_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            row_bits = in_a & {WIDTH{in_b[i]}};
            if (in_signed) begin
                if (i == WIDTH - 1) begin
                    row_bits[WIDTH-2:0] = ~row_bits[WIDTH-2:0];
                end else begin
                    row_bits[WIDTH-1] = ~row_bits[WIDTH-1];
                end
            end
            pp_next[i] = PW'(row_bits) << i;
        end
        pp_next[WIDTH] = in_signed ? CORR : '0;
    end

    // Each pair of chained 3:2 steps forms one 4:2 compressor; carries out of the top bit wrap away mod 2^PW.
    always_comb begin
        cs_sum   = pp1[0];
        cs_carry = pp1[1];
        cs_maj   = '0;
        for (int r = 2; r < ROWS; r++) begin
            cs_maj   = (cs_sum & cs_carry) | (cs_sum & pp1[r]) | (cs_carry & pp1[r]);
            cs_sum   = cs_sum ^ cs_carry ^ pp1[r];
            cs_carry = cs_maj << 1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            p3   <= '0;
            sgn3 <= 1'b0;
            tag3 <= '0;
        end else begin
            if (ready1) begin
                v1 <= in_valid;
            end
            if (ready2) begin
                v2 <= v1;
            end
            if (ready3) begin
                v3 <= v2;
                if (v2) begin
                    p3   <= sum2 + carry2;
                    sgn3 <= sgn2;
                    tag3 <= tag2;
                end
            end
        end
    end

    // Datapath registers in S1/S2 need no reset; their valid bits gate everything downstream.
    always_ff @(posedge clk) begin
        if (ready1 && in_valid) begin
            pp1  <= pp_next;
            sgn1 <= in_signed;
            tag1 <= in_tag;
        end
        if (ready2 && v1) begin
            sum2   <= cs_sum;
            carry2 <= cs_carry;
            sgn2   <= sgn1;
            tag2   <= tag1;
        end
    end

    assign out_valid  = v3;
    assign out_p      = p3;
    assign out_signed = sgn3;
    assign out_tag    = tag3;
endmodule

// File: tb/tb_pipelined_bw_multiplier.sv
// Self-checking bench: directed corner vectors, backpressure/bubble/reset sequences and
// randomized traffic for WIDTH=8 and WIDTH=16, scored against an arithmetic reference model.
module tb_pipelined_bw_multiplier;
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic [15:0] p;
    } vec_t;

    typedef struct {
        logic [63:0] p;
        logic        sgn;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        in_valid, in_ready, in_signed, out_valid, out_ready, out_signed;
    logic [7:0]  in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [15:0] out_p;
    logic [63:0] exp8;

    logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16, out_signed16;
    logic [15:0] in_a16, in_b16;
    logic [3:0]  in_tag16, out_tag16;
    logic [31:0] out_p16;
    logic [63:0] exp16;

    int   checks = 0;
    int   passes = 0;
    int   cycle = 0;
    int   out_count8 = 0;
    bit   mon_en = 1'b0;
    bit   lat_check = 1'b0;
    exp_t q8[$];
    exp_t q16[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    pipelined_bw_multiplier #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
        .out_signed(out_signed), .out_tag(out_tag)
    );

    pipelined_bw_multiplier #(.WIDTH(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_a(in_a16), .in_b(in_b16),
        .in_signed(in_signed16), .in_tag(in_tag16),
        .out_valid(out_valid16), .out_ready(out_ready16), .out_p(out_p16),
        .out_signed(out_signed16), .out_tag(out_tag16)
    );

    // Reference: interpret operands as w-bit signed or unsigned integers, multiply, keep 2w bits.
    function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn, input int w);
        longint sa, sb;
        sa = longint'({32'd0, a});
        sb = longint'({32'd0, b});
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Biases random operands towards zero, all-ones, most-negative and most-positive.
    function automatic logic [31:0] pickVal(input int w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        case ($urandom % 8)
            0: return 32'd0;
            1: return mask;
            2: return 32'd1 << (w - 1);
            3: return (32'd1 << (w - 1)) - 32'd1;
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one operation and holds it until it is accepted.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                                 input logic [3:0] tag, input logic [63:0] exp);
        int waited = 0;
        in_a = a; in_b = b; in_signed = sgn; in_tag = tag; exp8 = exp; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_wait", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic randOp8(input logic valid);
        in_a      = 8'(pickVal(8));
        in_b      = 8'(pickVal(8));
        in_signed = 1'($urandom % 2);
        in_tag    = 4'($urandom % 16);
        exp8      = refMul(32'(in_a), 32'(in_b), in_signed, 8);
        in_valid  = valid;
    endtask

    task automatic randOp16(input logic valid);
        in_a16      = 16'(pickVal(16));
        in_b16      = 16'(pickVal(16));
        in_signed16 = 1'($urandom % 2);
        in_tag16    = 4'($urandom % 16);
        exp16       = refMul(32'(in_a16), 32'(in_b16), in_signed16, 16);
        in_valid16  = valid;
    endtask

    task automatic waitDrain8();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q8.size() != 0 && n < 200) begin
            step();
            n++;
        end
        checkOutput("drain8_empty", 64'(q8.size()), 64'd0);
    endtask

    task automatic waitDrain16();
        int n = 0;
        in_valid16  = 1'b0;
        out_ready16 = 1'b1;
        while (q16.size() != 0 && n < 200) begin
            step();
            n++;
        end
        checkOutput("drain16_empty", 64'(q16.size()), 64'd0);
    endtask

    // Fills the pipe with n_ops stalled operations, then resets while another op is presented.
    task automatic resetMidFlight(input int n_ops);
        int base;
        out_ready = 1'b0;
        for (int k = 0; k < n_ops; k++) begin
            randOp8(1'b1);
            step();
        end
        randOp8(1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        base = out_count8;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
        step();
        repeat (6) step();
        checkOutput("rst_no_stale_outputs", 64'(out_count8 - base), 64'd0);
    endtask

    // Scoreboard for the 8-bit instance: order, tag, mode, product, in_ready and latency.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                q8.delete();
            end else begin
                checkOutput("in_ready8", 64'(in_ready), 64'(out_ready || q8.size() < 3));
                if (q8.size() == 0) begin
                    checkOutput("idle_out_valid8", 64'(out_valid), 64'd0);
                end else if (out_valid) begin
                    checkOutput("out_p8", 64'(out_p), q8[0].p);
                    checkOutput("out_tag8", 64'(out_tag), 64'(q8[0].tag));
                    checkOutput("out_signed8", 64'(out_signed), 64'(q8[0].sgn));
                    if (out_ready) begin
                        if (lat_check) checkOutput("latency8", 64'(cycle - q8[0].cyc), 64'd3);
                        void'(q8.pop_front());
                        out_count8++;
                    end
                end
                if (in_valid && in_ready) q8.push_back('{exp8, in_signed, in_tag, cycle});
            end
        end
    end

    // Scoreboard for the 16-bit instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                q16.delete();
            end else begin
                checkOutput("in_ready16", 64'(in_ready16), 64'(out_ready16 || q16.size() < 3));
                if (q16.size() == 0) begin
                    checkOutput("idle_out_valid16", 64'(out_valid16), 64'd0);
                end else if (out_valid16) begin
                    checkOutput("out_p16", 64'(out_p16), q16[0].p);
                    checkOutput("out_tag16", 64'(out_tag16), 64'(q16[0].tag));
                    checkOutput("out_signed16", 64'(out_signed16), 64'(q16[0].sgn));
                    if (out_ready16) void'(q16.pop_front());
                end
                if (in_valid16 && in_ready16) q16.push_back('{exp16, in_signed16, in_tag16, cycle});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int base;

        vecs[0] = '{8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[1] = '{8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[3] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
        vecs[4] = '{8'hFF, 8'h01, 1'b0, 16'h00FF};
        vecs[5] = '{8'hFF, 8'h01, 1'b1, 16'hFFFF};
        vecs[6] = '{8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[7] = '{8'h80, 8'hFF, 1'b1, 16'h0080};

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1; exp8 = '0;
        in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_signed16 = 1'b0; in_tag16 = '0; out_ready16 = 1'b1;
        exp16 = '0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;

        $display("[TB] reset values");
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_out_p", 64'(out_p), 64'd0);
        checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
        checkOutput("reset_out_signed", 64'(out_signed), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
        step();

        $display("[TB] directed vectors, back-to-back");
        lat_check = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sgn, 4'(i), {48'd0, vecs[i].p});
        end
        waitDrain8();
        lat_check = 1'b0;

        $display("[TB] backpressure");
        out_ready = 1'b0;
        acc = 0;
        base = out_count8;
        for (int k = 0; k < 10; k++) begin
            randOp8(1'b1);
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        checkOutput("bp_accepts", 64'(acc), 64'd3);
        waitDrain8();
        checkOutput("bp_drained", 64'(out_count8 - base), 64'd3);

        $display("[TB] bubble collapse");
        out_ready = 1'b0;
        randOp8(1'b1);
        step();
        in_valid = 1'b0;
        step();
        step();
        acc = 0;
        for (int k = 0; k < 5; k++) begin
            randOp8(1'b1);
            @(negedge clk);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        checkOutput("bubble_accepts", 64'(acc), 64'd2);
        waitDrain8();

        $display("[TB] reset mid-flight");
        resetMidFlight(3);
        resetMidFlight(2);

        $display("[TB] random traffic, WIDTH=8");
        for (int k = 0; k < 3000; k++) begin
            randOp8(1'($urandom % 4 != 0));
            out_ready = ($urandom % 4 != 0);
            step();
        end
        waitDrain8();

        $display("[TB] random traffic, WIDTH=16");
        for (int k = 0; k < 3000; k++) begin
            randOp16(1'($urandom % 4 != 0));
            out_ready16 = ($urandom % 4 != 0);
            step();
        end
        waitDrain16();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
